// File: rtl/rv_pkg.sv
// Shared definitions for the fetch/decode boundary: widths, NOP encoding,
// the buffered fetch-entry payload and the occupancy-counter width helper.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // One buffered fetch result; misalign is precomputed when the entry is captured.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            misalign;
  } fetch_entry_t;

  // Occupancy counter needs one extra bit to represent a completely full queue.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rv_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for a power-of-two circular buffer.
// Callers must qualify push/pop (no push when full, no pop when empty).
module rv_fifo_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [PW-1:0] wptr_o,
  output logic [PW-1:0] rptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state: flush collapses the queue onto the write pointer; otherwise
  // pointers advance on their handshakes and count tracks the difference.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push_i) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (pop_i) begin
        rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: buffers {pc, inst} pairs from fetch and presents
// them in order to decode, with flush on redirect and a precomputed pc+4.
module if_id_queue
  import rv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter int unsigned     XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INST = rv_pkg::NOP_INST,
  localparam int unsigned    PW       = $clog2(DEPTH),
  localparam int unsigned    CW       = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [XLEN-1:0] in_inst_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_pc4_o,
  output logic [XLEN-1:0] out_inst_o,
  output logic            out_misalign_o,
  output logic [CW-1:0]   count_o
);

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // Handshake qualification; readiness depends on stored state only.
  always_comb begin
    in_ready_o  = !full;
    out_valid_o = !empty;
    push        = in_valid_i && !full && !flush_i;
    pop         = !empty && out_ready_i && !flush_i;
  end

  rv_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .wptr_o  (wptr),
    .rptr_o  (rptr),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Payload to store; misalignment is resolved here so the read side stays a plain mux.
  always_comb begin
    wr_entry          = '0;
    wr_entry.pc       = rv_pkg::XLEN'(in_pc_i);
    wr_entry.inst     = rv_pkg::XLEN'(in_inst_i);
    wr_entry.misalign = |in_pc_i[1:0];
  end

  // Entry storage; cleared on reset so the idle head reads pc=0 / pc+4=4.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr] <= wr_entry;
    end
  end

  // Head presentation; inst and misalign are masked while nothing is valid.
  always_comb begin
    head           = mem_q[rptr];
    out_pc_o       = XLEN'(head.pc);
    out_pc4_o      = XLEN'(head.pc) + XLEN'(4);
    out_inst_o     = empty ? NOP_INST : XLEN'(head.inst);
    out_misalign_o = !empty && head.misalign;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the decoupling buffer.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_pc_i;
  logic [XLEN-1:0] in_inst_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_pc4_o;
  logic [XLEN-1:0] out_inst_o;
  logic            out_misalign_o;
  logic [CW-1:0]   count_o;

  int n_asserts;
  int n_fail;

  logic [31:0] mdl_pc   [$];
  logic [31:0] mdl_inst [$];
  bit          model_known;

  if_id_queue #(
    .DEPTH    (DEPTH),
    .XLEN     (XLEN),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_pc_i        (in_pc_i),
    .in_inst_i      (in_inst_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_pc_o       (out_pc_o),
    .out_pc4_o      (out_pc4_o),
    .out_inst_o     (out_inst_o),
    .out_misalign_o (out_misalign_o),
    .count_o        (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output against the model's current contents.
  task automatic cmp_outputs();
    int sz;
    sz = mdl_pc.size();
    check("count", 32'(count_o), 32'(sz));
    check("cnt_bound", 32'(count_o <= CW'(DEPTH)), 32'd1);
    check("out_valid", 32'(out_valid_o), 32'(sz != 0));
    check("in_ready", 32'(in_ready_o), 32'(sz < int'(DEPTH)));
    if (sz == 0) begin
      check("empty_inst", out_inst_o, NOP);
      check("empty_misalign", 32'(out_misalign_o), 32'd0);
    end else begin
      check("head_pc", out_pc_o, mdl_pc[0]);
      check("head_pc4", out_pc4_o, mdl_pc[0] + 32'd4);
      check("head_inst", out_inst_o, mdl_inst[0]);
      check("head_misalign", 32'(out_misalign_o), 32'(mdl_pc[0][1:0] != 2'b00));
    end
  endtask

  // Drive one cycle of inputs, check the pre-edge view, advance model and clock.
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] pc,
                      input logic [31:0] inst, input bit rd);
    bit do_push;
    bit do_pop;
    rst         = r;
    flush_i     = f;
    in_valid_i  = v;
    in_pc_i     = pc;
    in_inst_i   = inst;
    out_ready_i = rd;
    #1;
    if (model_known) cmp_outputs();
    if (r || f) begin
      mdl_pc.delete();
      mdl_inst.delete();
    end else begin
      do_pop  = (mdl_pc.size() > 0) && rd;
      do_push = v && (mdl_pc.size() < int'(DEPTH));
      if (do_pop) begin
        void'(mdl_pc.pop_front());
        void'(mdl_inst.pop_front());
      end
      if (do_push) begin
        mdl_pc.push_back(pc);
        mdl_inst.push_back(inst);
      end
    end
    if (r) model_known = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit rd);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rd);
  endtask

  initial begin
    n_asserts   = 0;
    n_fail      = 0;
    model_known = 1'b0;

    // Reset with fetch already offering an entry.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    check("rst_pc", out_pc_o, 32'h0);
    check("rst_pc4", out_pc4_o, 32'h4);
    check("rst_inst", out_inst_o, NOP);
    idle(1'b0);

    // Streaming with decode always ready.
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0010_0093, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h4, 32'h0020_0113, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h8, 32'h0030_0193, 1'b1);
    check("stream_pc4", out_pc4_o, 32'hC);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure until full, then a single-cycle drain.
    step(1'b0, 1'b0, 1'b1, 32'h10, 32'h1111_0010, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h14, 32'h1111_0014, 1'b0);
    check("full_ready", 32'(in_ready_o), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h18, 32'h1111_0018, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h18, 32'h1111_0018, 1'b1);
    check("after_pop_head", out_pc_o, 32'h14);
    step(1'b0, 1'b0, 1'b1, 32'h18, 32'h1111_0018, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with concurrent push and pop.
    step(1'b0, 1'b0, 1'b1, 32'h20, 32'h2222_0020, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h24, 32'h2222_0024, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h28, 32'h2222_0028, 1'b1);
    check("flush_count", 32'(count_o), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 32'h3333_0100, 1'b0);
    check("post_flush_head", out_pc_o, 32'h100);
    idle(1'b1);
    idle(1'b1);

    // PC wrap and misalignment.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h4444_0001, 1'b0);
    check("wrap_pc4", out_pc4_o, 32'h0);
    check("wrap_misalign", 32'(out_misalign_o), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h4444_0002, 1'b1);
    check("misalign_set", 32'(out_misalign_o), 32'd1);
    idle(1'b1);

    // Reset while full with traffic offered.
    step(1'b0, 1'b0, 1'b1, 32'h50, 32'h5555_0050, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h54, 32'h5555_0054, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h58, 32'h5555_0058, 1'b1);
    check("midrst_count", 32'(count_o), 32'd0);
    check("midrst_valid", 32'(out_valid_o), 32'd0);
    idle(1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), pc, $urandom, ($urandom_range(0, 1) == 1));
    end
    idle(1'b0);
    cmp_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
